// File: rtl/alu3_issue_ctrl_if.sv
// Bus between the action-ALU issue controller, its upstream producers and the ALU.
// The controller uses the slave modport; producers and the ALU use master.
interface alu3_issue_ctrl_if #(
   parameter int ACTION_LEN = 25,
   parameter int META_LEN   = 256
);

   logic [META_LEN-1:0]   meta_in;
   logic                  meta_valid_in;
   logic                  meta_ready_out;
   logic [ACTION_LEN-1:0] action_in;
   logic                  action_valid_in;
   logic                  action_ready_out;
   logic [META_LEN-1:0]   alu_meta_out;
   logic [ACTION_LEN-1:0] alu_action_out;
   logic                  alu_valid_out;
   logic                  alu_done_in;
   logic                  busy_out;
   logic                  overflow_err;
   logic                  timeout_err;
   logic [31:0]           issue_cnt;

   modport slave (
      input  meta_in,
      input  meta_valid_in,
      output meta_ready_out,
      input  action_in,
      input  action_valid_in,
      output action_ready_out,
      output alu_meta_out,
      output alu_action_out,
      output alu_valid_out,
      input  alu_done_in,
      output busy_out,
      output overflow_err,
      output timeout_err,
      output issue_cnt
   );

   modport master (
      output meta_in,
      output meta_valid_in,
      input  meta_ready_out,
      output action_in,
      output action_valid_in,
      input  action_ready_out,
      input  alu_meta_out,
      input  alu_action_out,
      input  alu_valid_out,
      output alu_done_in,
      input  busy_out,
      input  overflow_err,
      input  timeout_err,
      input  issue_cnt
   );

endinterface

// File: rtl/alu3_issue_ctrl.sv
// Issue controller for the single-slot action ALU: pairs buffered metadata and actions
// in arrival order and issues one pair at a time, waiting for ALU done or a timeout.
module alu3_issue_ctrl #(
   parameter int ACTION_LEN = 25,
   parameter int META_LEN   = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input logic              clk,
   input logic              rst,
   alu3_issue_ctrl_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
   localparam logic [7:0]    TIMEOUT_VAL = 8'(TIMEOUT);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   logic [META_LEN-1:0]   meta_mem_q [FIFO_DEPTH];
   logic [ACTION_LEN-1:0] act_mem_q  [FIFO_DEPTH];

   logic [AW-1:0] meta_wr_ptr_q, meta_wr_ptr_d;
   logic [AW-1:0] meta_rd_ptr_q, meta_rd_ptr_d;
   logic [CW-1:0] meta_cnt_q,    meta_cnt_d;
   logic [AW-1:0] act_wr_ptr_q,  act_wr_ptr_d;
   logic [AW-1:0] act_rd_ptr_q,  act_rd_ptr_d;
   logic [CW-1:0] act_cnt_q,     act_cnt_d;

   state_t                state_q,      state_d;
   logic [7:0]            timer_q,      timer_d;
   logic [META_LEN-1:0]   alu_meta_q,   alu_meta_d;
   logic [ACTION_LEN-1:0] alu_action_q, alu_action_d;
   logic                  alu_valid_q,  alu_valid_d;
   logic                  busy_q,       busy_d;
   logic                  overflow_q,   overflow_d;
   logic                  timeout_q,    timeout_d;
   logic [31:0]           issue_cnt_q,  issue_cnt_d;

   logic meta_ready;
   logic act_ready;
   logic meta_push;
   logic act_push;
   logic issue;

   // Ready comes only from registered occupancy, so there is no input-to-output path.
   assign meta_ready = (meta_cnt_q != FULL_CNT);
   assign act_ready  = (act_cnt_q != FULL_CNT);
   assign meta_push  = bus.meta_valid_in && meta_ready;
   assign act_push   = bus.action_valid_in && act_ready;
   assign issue      = (state_q == S_IDLE) && (meta_cnt_q != '0) && (act_cnt_q != '0);

   always_comb begin
      meta_wr_ptr_d = meta_wr_ptr_q;
      meta_rd_ptr_d = meta_rd_ptr_q;
      meta_cnt_d    = meta_cnt_q;
      act_wr_ptr_d  = act_wr_ptr_q;
      act_rd_ptr_d  = act_rd_ptr_q;
      act_cnt_d     = act_cnt_q;

      if (meta_push) begin
         meta_wr_ptr_d = meta_wr_ptr_q + AW'(1);
      end
      if (issue) begin
         meta_rd_ptr_d = meta_rd_ptr_q + AW'(1);
      end
      if (meta_push && !issue) begin
         meta_cnt_d = meta_cnt_q + CW'(1);
      end else if (!meta_push && issue) begin
         meta_cnt_d = meta_cnt_q - CW'(1);
      end

      if (act_push) begin
         act_wr_ptr_d = act_wr_ptr_q + AW'(1);
      end
      if (issue) begin
         act_rd_ptr_d = act_rd_ptr_q + AW'(1);
      end
      if (act_push && !issue) begin
         act_cnt_d = act_cnt_q + CW'(1);
      end else if (!act_push && issue) begin
         act_cnt_d = act_cnt_q - CW'(1);
      end
   end

   // busy is asserted only while WAIT persists, so it trails the issue pulse by one cycle.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      alu_meta_d   = alu_meta_q;
      alu_action_d = alu_action_q;
      alu_valid_d  = 1'b0;
      busy_d       = 1'b0;
      timeout_d    = timeout_q;
      issue_cnt_d  = issue_cnt_q;
      overflow_d   = overflow_q
                   | (bus.meta_valid_in && !meta_ready)
                   | (bus.action_valid_in && !act_ready);

      case (state_q)
         S_IDLE: begin
            if (issue) begin
               alu_meta_d   = meta_mem_q[meta_rd_ptr_q];
               alu_action_d = act_mem_q[act_rd_ptr_q];
               alu_valid_d  = 1'b1;
               issue_cnt_d  = issue_cnt_q + 32'd1;
               timer_d      = 8'd0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + 8'd1;
            if (bus.alu_done_in) begin
               state_d = S_IDLE;
            end else if (timer_q == TIMEOUT_VAL) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_wr_ptr_q <= '0;
         meta_rd_ptr_q <= '0;
         meta_cnt_q    <= '0;
         act_wr_ptr_q  <= '0;
         act_rd_ptr_q  <= '0;
         act_cnt_q     <= '0;
         state_q       <= S_IDLE;
         timer_q       <= '0;
         alu_meta_q    <= '0;
         alu_action_q  <= '0;
         alu_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         overflow_q    <= 1'b0;
         timeout_q     <= 1'b0;
         issue_cnt_q   <= '0;
      end else begin
         meta_wr_ptr_q <= meta_wr_ptr_d;
         meta_rd_ptr_q <= meta_rd_ptr_d;
         meta_cnt_q    <= meta_cnt_d;
         act_wr_ptr_q  <= act_wr_ptr_d;
         act_rd_ptr_q  <= act_rd_ptr_d;
         act_cnt_q     <= act_cnt_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         alu_meta_q    <= alu_meta_d;
         alu_action_q  <= alu_action_d;
         alu_valid_q   <= alu_valid_d;
         busy_q        <= busy_d;
         overflow_q    <= overflow_d;
         timeout_q     <= timeout_d;
         issue_cnt_q   <= issue_cnt_d;
      end
   end

   // Storage needs no reset: occupancy counts alone decide what is valid.
   always_ff @(posedge clk) begin
      if (meta_push) begin
         meta_mem_q[meta_wr_ptr_q] <= bus.meta_in;
      end
      if (act_push) begin
         act_mem_q[act_wr_ptr_q] <= bus.action_in;
      end
   end

   assign bus.meta_ready_out   = meta_ready;
   assign bus.action_ready_out = act_ready;
   assign bus.alu_meta_out     = alu_meta_q;
   assign bus.alu_action_out   = alu_action_q;
   assign bus.alu_valid_out    = alu_valid_q;
   assign bus.busy_out         = busy_q;
   assign bus.overflow_err     = overflow_q;
   assign bus.timeout_err      = timeout_q;
   assign bus.issue_cnt        = issue_cnt_q;

endmodule

// File: doc/alu3_issue_ctrl.md
# alu3_issue_ctrl

Issue controller for the single-slot action ALU in each match-action stage. Buffers PHV metadata and lookup actions that arrive independently, pairs them in order, and issues one pair at a time to the ALU. It holds off the next issue until the ALU returns its result valid or a timeout expires. It also provides ready backpressure upstream, sticky error flags and an issue counter.

## Interface
- ACTION_LEN, 25, action word width; opcode field is [24:21].
- META_LEN, 256, metadata width.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, ≥2.
- TIMEOUT, 15, maximum WAIT cycles before forced release; 1..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- meta_in  in  META_LEN  metadata from upstream stage.
- meta_valid_in  in  1  meta_in valid.
- meta_ready_out  out  1  metadata FIFO not full.
- action_in  in  ACTION_LEN  action from lookup RAM.
- action_valid_in  in  1  action_in valid.
- action_ready_out  out  1  action FIFO not full.
- alu_meta_out  out  META_LEN  to ALU metadata input (registered).
- alu_action_out  out  ACTION_LEN  to ALU action input (registered).
- alu_valid_out  out  1  one-cycle issue pulse; drives both ALU valid inputs.
- alu_done_in  in  1  ALU result valid.
- busy_out  out  1  high in WAIT state.
- overflow_err  out  1  sticky; a push was attempted while full.
- timeout_err  out  1  sticky; ALU did not answer within TIMEOUT.
- issue_cnt  out  32  number of issued pairs; wraps.

## Operation
- Two independent FIFOs (meta, action), each with depth FIFO_DEPTH and an occupancy count of width log2(FIFO_DEPTH)+1.
- Ready signals: ready = (count != FIFO_DEPTH), decoded from registered count only.
- Push: occurs on valid && ready. A valid input while full is dropped, FIFO unchanged, and the matching... sets overflow_err to 1 (stays 1 until reset).
- Push and pop in the same cycle on one FIFO: the count is unchanged and both take effect.
- Pairing is strictly FIFO order: the k-th meta pairs with the k-th action. There is no reordering and no matching on content.
- FSM, two states:
  - IDLE:
    - If both FIFOs are non-empty, on the edge: alu_meta_out ← meta head, alu_action_out ← action head, alu_valid_out ← 1, pop both, issue_cnt += 1, timer ← 0, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - alu_valid_out ← 0; timer += 1.
    - If alu_done_in, go to IDLE.
    - Else if timer == TIMEOUT, set timeout_err, go to IDLE.
- alu_meta_out and alu_action_out hold their last issued value between issues; they are not cleared.
- alu_done_in in IDLE is ignored.
- alu_done_in in the same cycle as the timeout compare counts as done; timeout_err is not set.
- issue_cnt wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - Outputs:
    - alu_meta_out = 0, alu_action_out = 0, alu_valid_out = 0.
    - busy_out = 0, overflow_err = 0, timeout_err = 0, issue_cnt = 0.
  - Internal state: both FIFOs empty, state = IDLE.
  - Consequently meta_ready_out = action_ready_out = 1.
- Reset asserted mid-WAIT or with FIFOs occupied: all contents are discarded and the block returns to the reset state immediately (asynchronous).
- Latency: the pair becomes complete (second element pushed) at edge N. alu_valid_out is high in cycle N+1, since the FIFO head is visible the cycle after the push.
- The ALU asserts its valid two cycles after sampling the issue. So alu_valid_out high in cycle t gives alu_done_in in cycle t+2 and IDLE in cycle t+3. The next alu_valid_out is high at the earliest in cycle t+4, giving a steady-state rate of 1 pair per 4 cycles.
- busy_out is high from cycle t+1 through the cycle that alu_done_in is seen.
- No combinational path from any input to any output.

## Test plan
- Reset, then push meta M0 (all bits 0xA5) and action 0x1800020 in the same cycle -> alu_valid_out high for exactly one cycle, one cycle after the push. alu_meta_out = M0, alu_action_out = 0x1800020, issue_cnt = 1.
- Push 3 metas first, then 3 actions 5 cycles later, with an ALU model that responds at +2 -> three issues in order, 4 cycles apart, pairs matched by index.
- Push 5 metas back-to-back with FIFO_DEPTH = 4 and no actions -> meta_ready_out is 0 after the 4th push, the 5th meta is dropped, and overflow_err = 1 and stays 1.
- ALU model never asserts done -> busy_out stays high for TIMEOUT cycles, then timeout_err = 1, the FSM is back in IDLE, and the next queued pair issues normally.
- Done arriving exactly at the timeout cycle -> timeout_err remains 0.
- Assert rst while in WAIT with 2 pairs queued -> all outputs go to 0 immediately, both ready signals are 1, and no issue occurs after reset is released.
